// File: rtl/sram_banked_dp_if.sv
// sram_banked_dp_if: port A/B request and response bundle for the banked packet-buffer SRAM.
interface sram_banked_dp_if #(
    parameter int Bits      = 16,
    parameter int Add_Width = 14
);
    logic                 iCEnA, iWEnA, iCEnB, iWEnB;
    logic [Bits-1:0]      iBWEnA, iBWEnB, iWDataA, iWDataB;
    logic [Add_Width-1:0] iAddrA, iAddrB;
    logic [Bits-1:0]      oRDataA, oRDataB;
    logic                 oRValidA, oRValidB, oCollision;
    logic [15:0]          oCollCnt;

    modport master (
        output iCEnA, iWEnA, iBWEnA, iAddrA, iWDataA,
        output iCEnB, iWEnB, iBWEnB, iAddrB, iWDataB,
        input  oRDataA, oRDataB, oRValidA, oRValidB, oCollision, oCollCnt
    );

    modport slave (
        input  iCEnA, iWEnA, iBWEnA, iAddrA, iWDataA,
        input  iCEnB, iWEnB, iBWEnB, iAddrB, iWDataB,
        output oRDataA, oRDataB, oRValidA, oRValidB, oCollision, oCollCnt
    );
endinterface

// File: rtl/sram_banked_dp.sv
// sram_banked_dp: single-clock true dual-port banked SRAM with read-first collisions,
// port-A write priority, optional output register and a saturating collision counter.
module sram_banked_dp #(
    parameter int Bits       = 16,
    parameter int Word_Depth = 16384,
    parameter int Banks      = 4,
    parameter int Out_Reg    = 0,
    parameter int Add_Width  = $clog2(Word_Depth),
    parameter int Bank_Width = (Banks > 1) ? $clog2(Banks) : 1
) (
    input logic             iClkA,
    input logic             iRst_n,
    sram_banked_dp_if.slave bus
);
    localparam int Sel_Bits   = $clog2(Banks);
    localparam int Off_Width  = Add_Width - Sel_Bits;
    localparam int Bank_Depth = Word_Depth / Banks;

    logic [1:0]                 rstSync;
    logic                       rstN;
    logic [Bank_Width-1:0]      bankA, bankB, selA, selB;
    logic [Off_Width-1:0]       offA, offB;
    logic                       rdA, rdB, wrA, wrB, coll;
    logic                       vldA, vldB;
    logic [Banks-1:0][Bits-1:0] qA, qB;
    logic [Bits-1:0]            muxA, muxB;

    // Reset asserts immediately but is released only after two clean clock edges
    always_ff @(posedge iClkA or negedge iRst_n)
        if (!iRst_n) rstSync <= '0;
        else         rstSync <= {rstSync[0], 1'b1};

    always_comb begin
        rstN  = rstSync[1];
        bankA = (Banks > 1) ? bus.iAddrA[Add_Width-1 -: Bank_Width] : '0;
        bankB = (Banks > 1) ? bus.iAddrB[Add_Width-1 -: Bank_Width] : '0;
        offA  = bus.iAddrA[Off_Width-1:0];
        offB  = bus.iAddrB[Off_Width-1:0];
        rdA   = !bus.iCEnA && bus.iWEnA;
        rdB   = !bus.iCEnB && bus.iWEnB;
        wrA   = !bus.iCEnA && !bus.iWEnA;
        wrB   = !bus.iCEnB && !bus.iWEnB;
        coll  = !bus.iCEnA && !bus.iCEnB && (bus.iAddrA == bus.iAddrB) && (wrA || wrB);
        muxA  = qA[selA];
        muxB  = qB[selB];
    end

    for (genvar b = 0; b < Banks; b++) begin : g_bank
        logic [Bits-1:0] mem [Bank_Depth];
        logic [Bits-1:0] rqA, rqB;
        logic            enA, enB;
        always_comb begin
            enA = !bus.iCEnA && (bankA == Bank_Width'(b));
            enB = !bus.iCEnB && (bankB == Bank_Width'(b));
        end
        // B's bits land first so A overwrites every bit both ports enable on a shared word
        always_ff @(posedge iClkA) begin
            for (int i = 0; i < Bits; i++) begin
                if (enB && !bus.iWEnB && !bus.iBWEnB[i]) mem[offB][i] <= bus.iWDataB[i];
                if (enA && !bus.iWEnA && !bus.iBWEnA[i]) mem[offA][i] <= bus.iWDataA[i];
            end
            if (enA && bus.iWEnA) rqA <= mem[offA];
            if (enB && bus.iWEnB) rqB <= mem[offB];
        end
        assign qA[b] = rqA;
        assign qB[b] = rqB;
    end

    always_ff @(posedge iClkA or negedge rstN)
        if (!rstN) begin
            selA           <= '0;
            selB           <= '0;
            vldA           <= 1'b0;
            vldB           <= 1'b0;
            bus.oCollision <= 1'b0;
            bus.oCollCnt   <= '0;
        end else begin
            if (rdA) selA <= bankA;
            if (rdB) selB <= bankB;
            vldA           <= rdA;
            vldB           <= rdB;
            bus.oCollision <= coll;
            if (coll && !(&bus.oCollCnt)) bus.oCollCnt <= bus.oCollCnt + 16'd1;
        end

    if (Out_Reg != 0) begin : g_oreg
        logic [Bits-1:0] dA, dB;
        logic            v2A, v2B;
        always_ff @(posedge iClkA or negedge rstN)
            if (!rstN) begin
                dA  <= '0;
                dB  <= '0;
                v2A <= 1'b0;
                v2B <= 1'b0;
            end else begin
                v2A <= vldA;
                v2B <= vldB;
                if (vldA) dA <= muxA;
                if (vldB) dB <= muxB;
            end
        always_comb begin
            bus.oRDataA  = dA;
            bus.oRDataB  = dB;
            bus.oRValidA = v2A;
            bus.oRValidB = v2B;
        end
    end else begin : g_noreg
        // Bank read registers are not reset, so gate them until a read has landed
        logic hasA, hasB;
        always_ff @(posedge iClkA or negedge rstN)
            if (!rstN) begin
                hasA <= 1'b0;
                hasB <= 1'b0;
            end else begin
                hasA <= hasA || rdA;
                hasB <= hasB || rdB;
            end
        always_comb begin
            bus.oRDataA  = hasA ? muxA : '0;
            bus.oRDataB  = hasB ? muxB : '0;
            bus.oRValidA = vldA;
            bus.oRValidB = vldB;
        end
    end
endmodule

// File: tb/tb_sram_banked_dp.sv
// tb_sram_banked_dp: table-driven vectors with a read scoreboard on an Out_Reg=0 instance,
// plus hand sequences for latency-2 pipelining and reset dropping on an Out_Reg=1 instance.
module tb_sram_banked_dp;
    typedef struct { logic [1:0] op; logic [13:0] addr; logic [15:0] data; logic [15:0] bwe; } port_t;
    typedef struct { port_t a; port_t b; logic coll; } vec_t;
    typedef struct { logic [15:0] data; int due; } sb_t;

    logic        clk = 1'b0;
    logic        rst0_n = 1'b0, rst1_n = 1'b0;
    int          cyc = 0;
    int          nCmp = 0, nErr = 0;
    sb_t         sbq[2][$];
    vec_t        tbl[$];
    logic [15:0] collExp;
    logic [15:0] expD [6];

    sram_banked_dp_if #(.Bits(16), .Add_Width(14)) if0 ();
    sram_banked_dp_if #(.Bits(16), .Add_Width(14)) if1 ();

    sram_banked_dp #(.Out_Reg(0)) dut0 (.iClkA(clk), .iRst_n(rst0_n), .bus(if0));
    sram_banked_dp #(.Out_Reg(1)) dut1 (.iClkA(clk), .iRst_n(rst1_n), .bus(if1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic port_t idle();
        return '{2'd0, 14'h0, 16'h0, 16'hFFFF};
    endfunction
    function automatic port_t rd(input logic [13:0] a, input logic [15:0] e);
        return '{2'd1, a, e, 16'hFFFF};
    endfunction
    function automatic port_t wr(input logic [13:0] a, input logic [15:0] d, input logic [15:0] m);
        return '{2'd2, a, d, m};
    endfunction

    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] want);
        nCmp++;
        if (got !== want) begin
            nErr++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", n, got, want, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input port_t a, input port_t b);
        if0.iCEnA   = (a.op == 2'd0);
        if0.iWEnA   = (a.op != 2'd2);
        if0.iAddrA  = a.addr;
        if0.iBWEnA  = (a.op == 2'd2) ? a.bwe : 16'hFFFF;
        if0.iWDataA = (a.op == 2'd2) ? a.data : 16'($urandom);
        if0.iCEnB   = (b.op == 2'd0);
        if0.iWEnB   = (b.op != 2'd2);
        if0.iAddrB  = b.addr;
        if0.iBWEnB  = (b.op == 2'd2) ? b.bwe : 16'hFFFF;
        if0.iWDataB = (b.op == 2'd2) ? b.data : 16'($urandom);
        if (a.op == 2'd1) sbq[0].push_back('{a.data, cyc + 1});
        if (b.op == 2'd1) sbq[1].push_back('{b.data, cyc + 1});
    endtask

    task automatic drive1(input port_t a, input port_t b);
        if1.iCEnA   = (a.op == 2'd0);
        if1.iWEnA   = (a.op != 2'd2);
        if1.iAddrA  = a.addr;
        if1.iBWEnA  = (a.op == 2'd2) ? a.bwe : 16'hFFFF;
        if1.iWDataA = (a.op == 2'd2) ? a.data : 16'($urandom);
        if1.iCEnB   = (b.op == 2'd0);
        if1.iWEnB   = (b.op != 2'd2);
        if1.iAddrB  = b.addr;
        if1.iBWEnB  = (b.op == 2'd2) ? b.bwe : 16'hFFFF;
        if1.iWDataB = (b.op == 2'd2) ? b.data : 16'($urandom);
    endtask

    // Scoreboard for dut0: every valid strobe pops one expected read, which must be due now
    always @(negedge clk) begin
        logic        v;
        logic [15:0] d;
        sb_t         e;
        string       pn;
        for (int p = 0; p < 2; p++) begin
            v  = (p == 0) ? if0.oRValidA : if0.oRValidB;
            d  = (p == 0) ? if0.oRDataA : if0.oRDataB;
            pn = (p == 0) ? "A" : "B";
            if (v && sbq[p].size() == 0) begin
                nCmp++;
                nErr++;
                $display("FAIL rd%s unexpected valid: got 1 want 0 (cycle %0d)", pn, cyc);
            end else if (v) begin
                e = sbq[p].pop_front();
                chk($sformatf("rd%s data", pn), d, e.data);
                chk($sformatf("rd%s cycle", pn), cyc, e.due);
            end else if (sbq[p].size() != 0 && sbq[p][0].due <= cyc) begin
                e = sbq[p].pop_front();
                nCmp++;
                nErr++;
                $display("FAIL rd%s missing valid: got 0 want 1 with %h (cycle %0d)", pn, e.data, cyc);
            end
        end
    end

    initial begin
        drive0(idle(), idle());
        drive1(idle(), idle());
        repeat (3) step();
        chk("rst0 rdataA", if0.oRDataA, 0);
        chk("rst0 rdataB", if0.oRDataB, 0);
        chk("rst0 valid", {if0.oRValidA, if0.oRValidB}, 0);
        chk("rst0 coll", if0.oCollision, 0);
        chk("rst0 cnt", if0.oCollCnt, 0);
        chk("rst1 outputs", {if1.oRDataA, if1.oRDataB, if1.oRValidA, if1.oRValidB, if1.oCollCnt}, 0);
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        repeat (4) step();

        tbl.push_back('{wr(14'h0000, 16'hA5A5, 16'h0000), idle(), 1'b0});
        tbl.push_back('{wr(14'h3FFF, 16'h5A5A, 16'h0000), idle(), 1'b0});
        tbl.push_back('{idle(), rd(14'h0000, 16'hA5A5), 1'b0});
        tbl.push_back('{idle(), rd(14'h3FFF, 16'h5A5A), 1'b0});
        tbl.push_back('{wr(14'h0100, 16'hFFFF, 16'h0000), idle(), 1'b0});
        tbl.push_back('{wr(14'h0100, 16'h0000, 16'hFF00), idle(), 1'b0});
        tbl.push_back('{idle(), rd(14'h0100, 16'hFF00), 1'b0});
        tbl.push_back('{wr(14'h1234, 16'h1111, 16'h0000), wr(14'h1234, 16'h2222, 16'h0000), 1'b1});
        tbl.push_back('{rd(14'h1234, 16'h1111), idle(), 1'b0});
        tbl.push_back('{wr(14'h0200, 16'h0F0F, 16'h0000), idle(), 1'b0});
        tbl.push_back('{wr(14'h0200, 16'hF0F0, 16'h0000), rd(14'h0200, 16'h0F0F), 1'b1});
        tbl.push_back('{idle(), rd(14'h0200, 16'hF0F0), 1'b0});
        tbl.push_back('{wr(14'h1000, 16'hABCD, 16'h0000), wr(14'h0FFF, 16'h1234, 16'h0000), 1'b0});
        tbl.push_back('{rd(14'h0FFF, 16'h1234), idle(), 1'b0});
        tbl.push_back('{rd(14'h1000, 16'hABCD), idle(), 1'b0});
        tbl.push_back('{rd(14'h0000, 16'hA5A5), rd(14'h0000, 16'hA5A5), 1'b0});
        tbl.push_back('{wr(14'h2000, 16'h1100, 16'hFF00), wr(14'h2000, 16'h22FF, 16'h0000), 1'b1});
        tbl.push_back('{idle(), rd(14'h2000, 16'h2200), 1'b0});
        tbl.push_back('{wr(14'h3000, 16'h7777, 16'h0000), wr(14'h1001, 16'h8888, 16'h0000), 1'b0});
        tbl.push_back('{rd(14'h1001, 16'h8888), rd(14'h3000, 16'h7777), 1'b0});
        tbl.push_back('{wr(14'h0005, 16'h5555, 16'h0000), wr(14'h0006, 16'h6666, 16'h0000), 1'b0});
        tbl.push_back('{rd(14'h0006, 16'h6666), rd(14'h0005, 16'h5555), 1'b0});
        tbl.push_back('{rd(14'h1234, 16'h1111), idle(), 1'b0});
        tbl.push_back('{wr(14'h1234, 16'h9999, 16'h0000), idle(), 1'b0});
        tbl.push_back('{idle(), idle(), 1'b0});
        tbl.push_back('{idle(), rd(14'h1234, 16'h9999), 1'b0});

        collExp = 16'd0;
        foreach (tbl[i]) begin
            drive0(tbl[i].a, tbl[i].b);
            step();
            if (tbl[i].coll) collExp = collExp + 16'd1;
            chk($sformatf("row%0d coll", i), if0.oCollision, tbl[i].coll);
            chk($sformatf("row%0d cnt", i), if0.oCollCnt, collExp);
        end
        drive0(idle(), idle());
        repeat (3) step();
        chk("A holds across write", if0.oRDataA, 16'h1111);
        chk("scoreboard drained", sbq[0].size() + sbq[1].size(), 0);

        // Saturation: every cycle is a write/write collision on one word
        for (int i = 0; i < 65540; i++) begin
            drive0(wr(14'h3FFE, 16'h0001, 16'h0000), wr(14'h3FFE, 16'h0002, 16'h0000));
            step();
            collExp = (collExp == 16'hFFFF) ? collExp : collExp + 16'd1;
            if (collExp >= 16'hFFFD) begin
                chk("sat coll", if0.oCollision, 1);
                chk("sat cnt", if0.oCollCnt, collExp);
            end
        end
        drive0(idle(), idle());
        step();
        chk("sat idle coll", if0.oCollision, 0);
        chk("sat idle cnt", if0.oCollCnt, 16'hFFFF);

        // Out_Reg=1: latency 2 and back-to-back ordering
        drive1(wr(14'h0010, 16'h1010, 16'h0000), idle());
        step();
        drive1(wr(14'h0011, 16'h2020, 16'h0000), idle());
        step();
        drive1(wr(14'h0012, 16'h3030, 16'h0000), wr(14'h0012, 16'hDEAD, 16'h0000));
        step();
        chk("d1 coll", if1.oCollision, 1);
        chk("d1 cnt", if1.oCollCnt, 1);
        expD = '{16'h0, 16'h1010, 16'h2020, 16'h3030, 16'h3030, 16'h3030};
        for (int k = 0; k < 6; k++) begin
            drive1(idle(), (k < 3) ? rd(14'(16 + k), 16'h0) : idle());
            step();
            chk($sformatf("d1 valid k%0d", k), if1.oRValidB, (k >= 1 && k <= 3));
            if (k >= 1) chk($sformatf("d1 data k%0d", k), if1.oRDataB, expD[k]);
        end

        // Reset lands mid-pipeline: in-flight reads vanish without a strobe
        drive1(idle(), rd(14'h0010, 16'h0));
        step();
        drive1(idle(), rd(14'h0011, 16'h0));
        step();
        rst1_n = 1'b0;
        drive1(idle(), rd(14'h0012, 16'h0));
        #1;
        chk("d1 rst immediate", {if1.oRDataB, if1.oRValidB, if1.oCollision, if1.oCollCnt}, 0);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("d1 rst held data", if1.oRDataB, 0);
            chk("d1 rst held flags", {if1.oRValidA, if1.oRValidB, if1.oCollision, if1.oCollCnt}, 0);
        end
        drive1(idle(), idle());
        rst1_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("d1 post-rst valid", if1.oRValidB, 0);
            chk("d1 post-rst data", if1.oRDataB, 0);
        end
        drive1(idle(), rd(14'h0012, 16'h0));
        step();
        drive1(idle(), idle());
        chk("d1 reread early", if1.oRValidB, 0);
        step();
        chk("d1 reread valid", if1.oRValidB, 1);
        chk("d1 reread data", if1.oRDataB, 16'h3030);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/sram_banked_dp.md
# sram_banked_dp

Parametrised, single-clock, true dual-port banked SRAM for the switch packet buffer. It generalises the fixed 4-bank 16x16k buffer to any power-of-two bank count, width and depth. It adds an optional output pipeline register, read-valid strobes, deterministic same-address collision resolution and a saturating collision counter. It sits between the ingress write engine (port A) and the egress read engine (port B), and either port may read or write.

## Interface
Parameters:
- Bits, 16, data word width.
- Word_Depth, 16384, total words; power of two, multiple of Banks.
- Banks, 4, bank count; power of two, 1..16.
- Out_Reg, 0, 0 = read latency 1, 1 = read latency 2 (extra output register).
- Add_Width, $clog2(Word_Depth), address width.
- Bank_Width, $clog2(Banks) (min 1), bank-select width; bank = iAddrX[Add_Width-1 -: Bank_Width].

Ports:
- iClkA  in  1  clock for both ports and all state.
- iRst_n  in  1  asynchronous, active-low reset.
- iCEnA / iCEnB  in  1  port chip enable, active low.
- iWEnA / iWEnB  in  1  0 = write, 1 = read (qualified by CEn).
- iBWEnA / iBWEnB  in  Bits  per-bit write enable, active low.
- iAddrA / iAddrB  in  Add_Width  word address.
- iWDataA / iWDataB  in  Bits  write data.
- oRDataA / oRDataB  out  Bits  read data; holds last read value.
- oRValidA / oRValidB  out  1  one-cycle strobe, read data valid.
- oCollision  out  1  one-cycle strobe, same-address conflict.
- oCollCnt  out  16  saturating count of collisions.

## Operation
- Op per port per cycle: idle (CEn=1), read (CEn=0, WEn=1), write (CEn=0, WEn=0).
- Only the addressed bank is enabled; other banks see CEn=1. Bank arrays are inferred, and their contents are not reset.
- Write: memory bits with BWEn=0 take new data; bits with BWEn=1 keep their old value. A write never changes oRData or oRValid on that port.
- Read: the bank-select bits are registered with the read (as in the existing buffer). The output mux uses the registered select, so later idle or write cycles do not disturb oRData.
- Different banks, or same bank with different addresses: both ports proceed independently.
- Same address, both writing: port A wins for every bit it enables. Port B bits are written only where A's BWEn=1 and B's BWEn=0. oCollision is raised.
- Same address, one port reads while the other writes: the read is read-first and returns the old word. oCollision is raised.
- Same address, both reading: both ports return the word. This is not a collision.
- oCollCnt increments by 1 per collision cycle and saturates at 16'hFFFF.

## Timing
- Reset (async assert, sync-to-clock release): oRDataA/B=0, oRValidA/B=0, oCollision=0, oCollCnt=0, bank-select registers=0. Any in-flight Out_Reg stage is cleared, so pending reads are dropped with no valid strobe.
- Out_Reg=0: read issued at edge t gives oRData/oRValid at t+1.
- Out_Reg=1: read issued at edge t gives oRData/oRValid at t+2.
- Back-to-back reads give one result per cycle, in order.
- oCollision asserts in the cycle after the colliding edge. oCollCnt reflects the collision on the same cycle that oCollision is high.
- A write at edge t followed by a read of the same address at t+1 on either port returns the new data.
- Address wrap: reading the last address of bank k and then the first address of bank k+1 needs no bubble.

## Test plan
- Banks=4, Bits=16, Out_Reg=0. Write 16'hA5A5 to 0x0000 and 16'h5A5A to 0x3FFF via A. Read both via B on consecutive cycles. oRDataB=A5A5 then 5A5A at t+1 and t+2, with oRValidB high for 2 cycles.
- Write 16'hFFFF, then write 16'h0000 with BWEn=16'hFF00 (low byte enabled), then read. Result is 16'hFF00.
- Same cycle, addr 0x1234: A writes 16'h1111 and B writes 16'h2222, all bits enabled. Then read. Result is 16'h1111; oCollision pulses once; oCollCnt=1.
- Addr holds 16'h0F0F. A writes 16'hF0F0 while B reads the same address. B returns 16'h0F0F, a subsequent read returns 16'hF0F0, and oCollCnt increments.
- Out_Reg=1: issue 3 back-to-back B reads, and assert iRst_n low after the 2nd issue edge. No oRValidB is seen for the dropped reads, and all outputs are 0 during reset.
- Force 65540 collisions. oCollCnt stops at 16'hFFFF while oCollision keeps pulsing.
